// File: rtl/itlb_miss_ctrl_if.sv
// Signal bundle between the ITLB miss controller and its neighbours:
// fetch miss ports, page-table walker, ITLB fill/invalidate ports and sfence.
interface itlb_miss_ctrl_if #(
  parameter int VA_SZ = 48,
  parameter int NPHYS = 44
);
  localparam int VPN_W = VA_SZ - 12;
  localparam int PPN_W = NPHYS - 12;

  logic             miss_req_0;
  logic [VPN_W-1:0] miss_vaddr_0;
  logic [15:0]      miss_asid_0;
  logic             miss_req_1;
  logic [VPN_W-1:0] miss_vaddr_1;
  logic [15:0]      miss_asid_1;
  logic             miss_done_0;
  logic             miss_done_1;
  logic             miss_fault;
  logic             miss_retry;

  logic             ptw_req;
  logic             ptw_ready;
  logic [VPN_W-1:0] ptw_vaddr;
  logic [15:0]      ptw_asid;
  logic             ptw_rsp_valid;
  logic             ptw_rsp_fault;
  logic [PPN_W-1:0] ptw_rsp_paddr;
  logic [3:0]       ptw_rsp_gaux;
  logic [3:0]       ptw_rsp_size;

  logic             tlb_wr_entry;
  logic [VPN_W-1:0] tlb_wr_vaddr;
  logic [15:0]      tlb_wr_asid;
  logic [PPN_W-1:0] tlb_wr_paddr;
  logic [3:0]       tlb_wr_gaux;
  logic [3:0]       tlb_wr_size;

  logic             sfence_req;
  logic             sfence_asid_en;
  logic [15:0]      sfence_asid;
  logic             sfence_addr_en;
  logic [VPN_W-1:0] sfence_vaddr;
  logic             sfence_unified;
  logic             sfence_ack;

  logic             tlb_inv;
  logic             tlb_inv_asid_en;
  logic [15:0]      tlb_inv_asid;
  logic             tlb_inv_addr_en;
  logic [VPN_W-1:0] tlb_inv_vaddr;
  logic             tlb_inv_unified;

  // The controller side.
  modport slave (
    input  miss_req_0, miss_vaddr_0, miss_asid_0,
    input  miss_req_1, miss_vaddr_1, miss_asid_1,
    output miss_done_0, miss_done_1, miss_fault, miss_retry,
    output ptw_req, ptw_vaddr, ptw_asid,
    input  ptw_ready, ptw_rsp_valid, ptw_rsp_fault, ptw_rsp_paddr, ptw_rsp_gaux, ptw_rsp_size,
    output tlb_wr_entry, tlb_wr_vaddr, tlb_wr_asid, tlb_wr_paddr, tlb_wr_gaux, tlb_wr_size,
    input  sfence_req, sfence_asid_en, sfence_asid, sfence_addr_en, sfence_vaddr, sfence_unified,
    output sfence_ack,
    output tlb_inv, tlb_inv_asid_en, tlb_inv_asid, tlb_inv_addr_en, tlb_inv_vaddr, tlb_inv_unified
  );

  // The surrounding fetch/walker/TLB environment.
  modport master (
    output miss_req_0, miss_vaddr_0, miss_asid_0,
    output miss_req_1, miss_vaddr_1, miss_asid_1,
    input  miss_done_0, miss_done_1, miss_fault, miss_retry,
    input  ptw_req, ptw_vaddr, ptw_asid,
    output ptw_ready, ptw_rsp_valid, ptw_rsp_fault, ptw_rsp_paddr, ptw_rsp_gaux, ptw_rsp_size,
    input  tlb_wr_entry, tlb_wr_vaddr, tlb_wr_asid, tlb_wr_paddr, tlb_wr_gaux, tlb_wr_size,
    output sfence_req, sfence_asid_en, sfence_asid, sfence_addr_en, sfence_vaddr, sfence_unified,
    input  sfence_ack,
    input  tlb_inv, tlb_inv_asid_en, tlb_inv_asid, tlb_inv_addr_en, tlb_inv_vaddr, tlb_inv_unified
  );
endinterface

// File: rtl/itlb_miss_ctrl.sv
// ITLB update sequencer: arbitrates/merges fetch misses, runs one page-table
// walk at a time, fills the ITLB and serialises sfence invalidations.
module itlb_miss_ctrl #(
  parameter int VA_SZ   = 48,
  parameter int NPHYS   = 44,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  itlb_miss_ctrl_if.slave   bus
);

  localparam int VPN_W = VA_SZ - 12;
  localparam int PPN_W = NPHYS - 12;
  localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TIMEOUT_M1 = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, FILL, INV} state_e;

  state_e           state_q, state_d;
  logic             lastPort_q, lastPort_d;
  logic             abort_q, abort_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [1:0]       mask_q, mask_d;
  logic [VPN_W-1:0] vaddr_q, vaddr_d;
  logic [15:0]      asid_q, asid_d;
  logic [PPN_W-1:0] paddr_q, paddr_d;
  logic [3:0]       gaux_q, gaux_d;
  logic [3:0]       size_q, size_d;

  logic             anyReq;
  logic             pick;
  logic             sameReq;
  logic [1:0]       pickMask;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      lastPort_q <= 1'b1;
      abort_q    <= 1'b0;
      timer_q    <= '0;
      mask_q     <= '0;
      vaddr_q    <= '0;
      asid_q     <= '0;
      paddr_q    <= '0;
      gaux_q     <= '0;
      size_q     <= '0;
    end else begin
      state_q    <= state_d;
      lastPort_q <= lastPort_d;
      abort_q    <= abort_d;
      timer_q    <= timer_d;
      mask_q     <= mask_d;
      vaddr_q    <= vaddr_d;
      asid_q     <= asid_d;
      paddr_q    <= paddr_d;
      gaux_q     <= gaux_d;
      size_q     <= size_d;
    end
  end

  // Round-robin on a tie; an identical request on the other port rides along.
  always_comb begin
    anyReq   = bus.miss_req_0 | bus.miss_req_1;
    pick     = (bus.miss_req_0 & bus.miss_req_1) ? ~lastPort_q : bus.miss_req_1;
    sameReq  = (bus.miss_vaddr_0 == bus.miss_vaddr_1) && (bus.miss_asid_0 == bus.miss_asid_1);
    pickMask = pick ? {1'b1, bus.miss_req_0 & sameReq}
                    : {bus.miss_req_1 & sameReq, 1'b1};
  end

  always_comb begin
    state_d    = state_q;
    lastPort_d = lastPort_q;
    abort_d    = abort_q;
    timer_d    = timer_q;
    mask_d     = mask_q;
    vaddr_d    = vaddr_q;
    asid_d     = asid_q;
    paddr_d    = paddr_q;
    gaux_d     = gaux_q;
    size_d     = size_q;

    bus.miss_done_0     = 1'b0;
    bus.miss_done_1     = 1'b0;
    bus.miss_fault      = 1'b0;
    bus.miss_retry      = 1'b0;
    bus.ptw_req         = 1'b0;
    bus.ptw_vaddr       = '0;
    bus.ptw_asid        = '0;
    bus.tlb_wr_entry    = 1'b0;
    bus.tlb_wr_vaddr    = '0;
    bus.tlb_wr_asid     = '0;
    bus.tlb_wr_paddr    = '0;
    bus.tlb_wr_gaux     = '0;
    bus.tlb_wr_size     = '0;
    bus.sfence_ack      = 1'b0;
    bus.tlb_inv         = 1'b0;
    bus.tlb_inv_asid_en = 1'b0;
    bus.tlb_inv_asid    = '0;
    bus.tlb_inv_addr_en = 1'b0;
    bus.tlb_inv_vaddr   = '0;
    bus.tlb_inv_unified = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.sfence_req) begin
          state_d = INV;
        end else if (anyReq) begin
          lastPort_d = pick;
          vaddr_d    = pick ? bus.miss_vaddr_1 : bus.miss_vaddr_0;
          asid_d     = pick ? bus.miss_asid_1 : bus.miss_asid_0;
          mask_d     = pickMask;
          state_d    = REQ;
        end
      end

      // A walker handshake beats an sfence arriving in the same cycle.
      REQ: begin
        bus.ptw_req   = 1'b1;
        bus.ptw_vaddr = vaddr_q;
        bus.ptw_asid  = asid_q;
        if (bus.ptw_ready) begin
          timer_d = '0;
          state_d = WAIT;
        end else if (bus.sfence_req) begin
          abort_d = 1'b1;
          state_d = INV;
        end
      end

      // A pending sfence waits here, so the fill always lands before the invalidate.
      WAIT: begin
        timer_d = timer_q + 1'b1;
        if (bus.ptw_rsp_valid) begin
          if (bus.ptw_rsp_fault) begin
            bus.miss_done_0 = mask_q[0];
            bus.miss_done_1 = mask_q[1];
            bus.miss_fault  = 1'b1;
            state_d         = IDLE;
          end else begin
            paddr_d = bus.ptw_rsp_paddr;
            gaux_d  = bus.ptw_rsp_gaux;
            size_d  = bus.ptw_rsp_size;
            state_d = FILL;
          end
        end else if (timer_q == TIMEOUT_M1) begin
          bus.miss_done_0 = mask_q[0];
          bus.miss_done_1 = mask_q[1];
          bus.miss_retry  = 1'b1;
          state_d         = IDLE;
        end
      end

      FILL: begin
        bus.tlb_wr_entry = 1'b1;
        bus.tlb_wr_vaddr = vaddr_q;
        bus.tlb_wr_asid  = asid_q;
        bus.tlb_wr_paddr = paddr_q;
        bus.tlb_wr_gaux  = gaux_q;
        bus.tlb_wr_size  = size_q;
        bus.miss_done_0  = mask_q[0];
        bus.miss_done_1  = mask_q[1];
        state_d          = IDLE;
      end

      INV: begin
        bus.tlb_inv         = 1'b1;
        bus.sfence_ack      = 1'b1;
        bus.tlb_inv_asid_en = bus.sfence_asid_en;
        bus.tlb_inv_asid    = bus.sfence_asid;
        bus.tlb_inv_addr_en = bus.sfence_addr_en;
        bus.tlb_inv_vaddr   = bus.sfence_vaddr;
        bus.tlb_inv_unified = bus.sfence_unified;
        if (abort_q) begin
          bus.miss_done_0 = mask_q[0];
          bus.miss_done_1 = mask_q[1];
          bus.miss_retry  = 1'b1;
          abort_d         = 1'b0;
        end
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_itlb_miss_ctrl.sv
// Directed bench for itlb_miss_ctrl: walks, merging, arbitration, sfence
// ordering/abort, faults, timeout and mid-walk reset.
module tb_itlb_miss_ctrl;

  localparam int VA_SZ   = 48;
  localparam int NPHYS   = 44;
  localparam int TIMEOUT = 255;

  logic clk = 1'b0;
  logic reset;
  int   checkCount = 0;
  int   passCount  = 0;
  logic earlyDone;

  always #5 clk = ~clk;

  itlb_miss_ctrl_if #(.VA_SZ(VA_SZ), .NPHYS(NPHYS)) bus ();

  itlb_miss_ctrl #(.VA_SZ(VA_SZ), .NPHYS(NPHYS), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clearInputs();
    bus.miss_req_0     = 0; bus.miss_vaddr_0 = '0; bus.miss_asid_0 = '0;
    bus.miss_req_1     = 0; bus.miss_vaddr_1 = '0; bus.miss_asid_1 = '0;
    bus.ptw_ready      = 0; bus.ptw_rsp_valid = 0; bus.ptw_rsp_fault = 0;
    bus.ptw_rsp_paddr  = '0; bus.ptw_rsp_gaux = '0; bus.ptw_rsp_size = '0;
    bus.sfence_req     = 0; bus.sfence_asid_en = 0; bus.sfence_asid = '0;
    bus.sfence_addr_en = 0; bus.sfence_vaddr = '0; bus.sfence_unified = 0;
  endtask

  task automatic applyStimulus(input logic r0, input logic [35:0] v0, input logic [15:0] a0,
                               input logic r1, input logic [35:0] v1, input logic [15:0] a1);
    bus.miss_req_0 = r0; bus.miss_vaddr_0 = v0; bus.miss_asid_0 = a0;
    bus.miss_req_1 = r1; bus.miss_vaddr_1 = v1; bus.miss_asid_1 = a1;
  endtask

  // Called in the IDLE cycle holding the requests; ends in the FILL cycle.
  task automatic serveWalk(input logic [35:0] va, input logic [15:0] asid, input logic [31:0] pa,
                           input logic [3:0] gaux, input logic [3:0] size, input int idleWait,
                           input logic exp0, input logic exp1);
    nextCycle();
    bus.ptw_ready = 1;
    settle();
    checkOutput("reqValid", bus.ptw_req, 1);
    checkOutput("reqVaddr", bus.ptw_vaddr, va);
    checkOutput("reqAsid", bus.ptw_asid, asid);
    nextCycle();
    bus.ptw_ready = 0;
    for (int i = 0; i < idleWait; i++) begin
      settle();
      checkOutput("waitQuiet", {bus.ptw_req, bus.miss_done_1, bus.miss_done_0, bus.tlb_wr_entry}, 0);
      nextCycle();
    end
    bus.ptw_rsp_valid = 1; bus.ptw_rsp_fault = 0;
    bus.ptw_rsp_paddr = pa; bus.ptw_rsp_gaux = gaux; bus.ptw_rsp_size = size;
    settle();
    checkOutput("rspNoDone", {bus.miss_done_1, bus.miss_done_0}, 0);
    nextCycle();
    bus.ptw_rsp_valid = 0;
    settle();
    checkOutput("fillStrobe", bus.tlb_wr_entry, 1);
    checkOutput("fillVaddr", bus.tlb_wr_vaddr, va);
    checkOutput("fillAsid", bus.tlb_wr_asid, asid);
    checkOutput("fillPaddr", bus.tlb_wr_paddr, pa);
    checkOutput("fillGaux", bus.tlb_wr_gaux, gaux);
    checkOutput("fillSize", bus.tlb_wr_size, size);
    checkOutput("fillDone", {bus.miss_done_1, bus.miss_done_0}, {exp1, exp0});
    checkOutput("fillFlags", {bus.miss_fault, bus.miss_retry}, 0);
    checkOutput("fillNoInv", {bus.tlb_inv, bus.sfence_ack}, 0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: run exceeded its time budget");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clearInputs();
    reset = 1;
    repeat (2) nextCycle();
    settle();
    checkOutput("rstPtwReq", bus.ptw_req, 0);
    checkOutput("rstDone", {bus.miss_done_1, bus.miss_done_0, bus.miss_fault, bus.miss_retry}, 0);
    checkOutput("rstWrInv", {bus.tlb_wr_entry, bus.tlb_inv, bus.sfence_ack}, 0);
    reset = 0;

    // Single port-0 miss, response five cycles after the request.
    nextCycle();
    applyStimulus(1, 36'h12345, 16'd3, 0, '0, '0);
    settle();
    checkOutput("idleNoReq", bus.ptw_req, 0);
    serveWalk(36'h12345, 16'd3, 32'hABC, 4'h5, 4'h0, 3, 1, 0);
    nextCycle();
    applyStimulus(0, '0, '0, 0, '0, '0);
    settle();
    checkOutput("afterFill", {bus.tlb_wr_entry, bus.miss_done_1, bus.miss_done_0}, 0);

    // Identical requests merge into one walk.
    nextCycle();
    applyStimulus(1, 36'h40, 16'd7, 1, 36'h40, 16'd7);
    serveWalk(36'h40, 16'd7, 32'h55, 4'h8, 4'b0010, 0, 1, 1);
    nextCycle();
    applyStimulus(0, '0, '0, 0, '0, '0);
    settle();
    checkOutput("dupSingleWalkA", bus.ptw_req, 0);
    nextCycle();
    settle();
    checkOutput("dupSingleWalkB", bus.ptw_req, 0);

    // Distinct requests alternate: port 0, port 1, port 0.
    nextCycle();
    applyStimulus(1, 36'h100, 16'd1, 1, 36'h200, 16'd1);
    serveWalk(36'h100, 16'd1, 32'h1000, 4'h1, 4'h0, 0, 1, 0);
    nextCycle();
    applyStimulus(1, 36'h300, 16'd1, 1, 36'h200, 16'd1);
    serveWalk(36'h200, 16'd1, 32'h2000, 4'h2, 4'h0, 1, 0, 1);
    nextCycle();
    applyStimulus(1, 36'h300, 16'd1, 1, 36'h400, 16'd1);
    serveWalk(36'h300, 16'd1, 32'h3000, 4'h3, 4'h1, 0, 1, 0);
    nextCycle();
    applyStimulus(0, '0, '0, 0, '0, '0);

    // sfence aborts a walk still waiting in REQ.
    nextCycle();
    applyStimulus(1, 36'h777, 16'd9, 0, '0, '0);
    nextCycle();
    bus.sfence_req = 1; bus.sfence_asid_en = 1; bus.sfence_asid = 16'd5;
    settle();
    checkOutput("abortReqValid", bus.ptw_req, 1);
    checkOutput("abortNoAckYet", bus.sfence_ack, 0);
    nextCycle();
    settle();
    checkOutput("abortInv", {bus.tlb_inv, bus.sfence_ack}, 2'b11);
    checkOutput("abortInvAsid", {bus.tlb_inv_asid_en, bus.tlb_inv_asid}, {1'b1, 16'd5});
    checkOutput("abortDone", {bus.miss_done_1, bus.miss_done_0, bus.miss_retry, bus.miss_fault}, 4'b0110);
    checkOutput("abortNoWalk", {bus.ptw_req, bus.tlb_wr_entry}, 0);
    nextCycle();
    clearInputs();
    settle();
    checkOutput("abortQuiet", {bus.tlb_inv, bus.sfence_ack, bus.miss_done_0, bus.ptw_req}, 0);

    // sfence during WAIT is held off until after the fill.
    nextCycle();
    applyStimulus(0, '0, '0, 1, 36'h999, 16'd2);
    nextCycle();
    bus.ptw_ready = 1;
    nextCycle();
    bus.ptw_ready = 0;
    bus.sfence_req = 1; bus.sfence_addr_en = 1; bus.sfence_vaddr = 36'h999; bus.sfence_unified = 1;
    for (int i = 0; i < 3; i++) begin
      settle();
      checkOutput("waitNoAck", {bus.sfence_ack, bus.tlb_inv}, 0);
      nextCycle();
    end
    bus.ptw_rsp_valid = 1; bus.ptw_rsp_paddr = 32'h321; bus.ptw_rsp_gaux = 4'h9; bus.ptw_rsp_size = 4'h0;
    nextCycle();
    bus.ptw_rsp_valid = 0;
    settle();
    checkOutput("sfFill", {bus.tlb_wr_entry, bus.miss_done_1, bus.sfence_ack, bus.tlb_inv}, 4'b1100);
    checkOutput("sfFillPaddr", bus.tlb_wr_paddr, 32'h321);
    nextCycle();
    applyStimulus(0, '0, '0, 0, '0, '0);
    settle();
    checkOutput("sfIdleGap", {bus.sfence_ack, bus.tlb_inv, bus.tlb_wr_entry}, 0);
    nextCycle();
    settle();
    checkOutput("sfInv", {bus.tlb_inv, bus.sfence_ack}, 2'b11);
    checkOutput("sfInvFields", {bus.tlb_inv_addr_en, bus.tlb_inv_asid_en, bus.tlb_inv_unified}, 3'b101);
    checkOutput("sfInvVaddr", bus.tlb_inv_vaddr, 36'h999);
    checkOutput("sfInvNoDone", {bus.miss_done_1, bus.miss_done_0}, 0);
    nextCycle();
    clearInputs();

    // Faulting walk.
    nextCycle();
    applyStimulus(1, 36'h55, 16'd1, 0, '0, '0);
    nextCycle();
    bus.ptw_ready = 1;
    nextCycle();
    bus.ptw_ready = 0;
    bus.ptw_rsp_valid = 1; bus.ptw_rsp_fault = 1;
    settle();
    checkOutput("faultDone", {bus.miss_done_1, bus.miss_done_0, bus.miss_fault, bus.miss_retry}, 4'b0110);
    checkOutput("faultNoFill", bus.tlb_wr_entry, 0);
    nextCycle();
    clearInputs();
    settle();
    checkOutput("faultAfter", {bus.tlb_wr_entry, bus.miss_done_0, bus.ptw_req}, 0);

    // Walker never answers: retry after TIMEOUT cycles, late answer ignored.
    nextCycle();
    applyStimulus(0, '0, '0, 1, 36'h66, 16'd4);
    nextCycle();
    bus.ptw_ready = 1;
    nextCycle();
    bus.ptw_ready = 0;
    earlyDone = 0;
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      settle();
      earlyDone = earlyDone | bus.miss_done_0 | bus.miss_done_1;
      nextCycle();
    end
    settle();
    checkOutput("toEarly", earlyDone, 0);
    checkOutput("toDone", {bus.miss_done_1, bus.miss_done_0, bus.miss_retry, bus.miss_fault}, 4'b1010);
    checkOutput("toNoFill", bus.tlb_wr_entry, 0);
    nextCycle();
    applyStimulus(0, '0, '0, 0, '0, '0);
    bus.ptw_rsp_valid = 1; bus.ptw_rsp_paddr = 32'h123;
    settle();
    checkOutput("lateIdle", {bus.ptw_req, bus.miss_done_1, bus.miss_done_0}, 0);
    nextCycle();
    bus.ptw_rsp_valid = 0;
    settle();
    checkOutput("lateIgnored", bus.tlb_wr_entry, 0);

    // Reset mid-walk, then a fresh miss.
    nextCycle();
    applyStimulus(1, 36'hAA, 16'd6, 0, '0, '0);
    nextCycle();
    bus.ptw_ready = 1;
    nextCycle();
    bus.ptw_ready = 0;
    reset = 1;
    nextCycle();
    reset = 0;
    applyStimulus(0, '0, '0, 0, '0, '0);
    settle();
    checkOutput("midRstQuiet", {bus.ptw_req, bus.miss_done_1, bus.miss_done_0, bus.miss_retry,
                                bus.tlb_wr_entry, bus.tlb_inv, bus.sfence_ack}, 0);
    checkOutput("midRstVaddr", bus.ptw_vaddr, 0);
    nextCycle();
    applyStimulus(0, '0, '0, 1, 36'hBB, 16'd8);
    serveWalk(36'hBB, 16'd8, 32'h77, 4'h1, 4'b0100, 1, 0, 1);
    nextCycle();
    applyStimulus(0, '0, '0, 0, '0, '0);

    // sfence beats a simultaneous miss in IDLE; the miss follows.
    nextCycle();
    applyStimulus(1, 36'h10, 16'd2, 0, '0, '0);
    bus.sfence_req = 1;
    settle();
    checkOutput("prioNoReq", bus.ptw_req, 0);
    nextCycle();
    settle();
    checkOutput("prioInv", {bus.tlb_inv, bus.sfence_ack, bus.miss_done_0, bus.miss_retry}, 4'b1100);
    nextCycle();
    bus.sfence_req = 0;
    serveWalk(36'h10, 16'd2, 32'h4444, 4'h8, 4'b1000, 0, 1, 0);
    nextCycle();
    clearInputs();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
